// File: rtl/gpio_pio_v2_pkg.sv
// Shared constants for the gpio_pio_v2 block: Avalon word addresses and bus width.
package gpio_pio_v2_pkg;
    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    typedef struct packed {
        logic [2:0]        addr;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } avs_req_t;
endpackage

// File: rtl/gpio_pio_debounce.sv
// One input bit: 2-flop synchroniser followed by a stable-count debouncer.
module gpio_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign dout = sync2_q;
        end else begin : g_cnt
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          deb_q, deb_d;

            // Accepting at CNT_MAX also clears the count, so it never wraps.
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (sync2_q != deb_q) begin
                    if (cnt_q == CNT_MAX) deb_d = sync2_q;
                    else                  cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign dout = deb_q;
        end
    endgenerate
endmodule

// File: rtl/gpio_pio_v2.sv
// Avalon-MM parallel I/O: output/direction registers, debounced inputs,
// edge capture with masked level interrupt.
module gpio_pio_v2
    import gpio_pio_v2_pkg::*;
#(
    parameter int          WIDTH           = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] OUT_RESET       = 32'h0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe_port,
    output logic              irq
);
    avs_req_t req;
    assign req = '{addr: avs_address, rd: avs_read, wr: avs_write, wdata: avs_writedata};

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] wd, rd_mux, cap_set;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_in
        gpio_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk  (clk_clk),
            .rst_n(reset_reset_n),
            .din  (in_port[i]),
            .dout (deb[i])
        );
    end

    assign wd      = req.wdata[WIDTH-1:0];
    assign cap_set = (deb & ~deb_prev_q & rise_en_q) | (~deb & deb_prev_q & fall_en_q);

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        cap_d     = cap_q;
        if (req.wr) begin
            case (req.addr)
                ADDR_DATA:     out_d     = wd;
                ADDR_DIR:      dir_d     = wd;
                ADDR_IRQ_MASK: mask_d    = wd;
                ADDR_EDGE_CAP: cap_d     = cap_q & ~wd;
                ADDR_OUT_SET:  out_d     = out_q | wd;
                ADDR_OUT_CLR:  out_d     = out_q & ~wd;
                ADDR_RISE_EN:  rise_en_d = wd;
                default:       fall_en_d = wd;
            endcase
        end
        // New captures are OR'd after the clear so a coincident edge is kept.
        cap_d = cap_d | cap_set;
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        rd_mux = '0;
        case (req.addr)
            ADDR_DATA:     rd_mux = deb;
            ADDR_DIR:      rd_mux = dir_q;
            ADDR_IRQ_MASK: rd_mux = mask_q;
            ADDR_EDGE_CAP: rd_mux = cap_q;
            ADDR_RISE_EN:  rd_mux = rise_en_q;
            ADDR_FALL_EN:  rd_mux = fall_en_q;
            default:       rd_mux = '0;
        endcase
        readdata_d = req.rd ? DATA_W'(rd_mux) : readdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q      <= OUT_RESET[WIDTH-1:0];
            dir_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            deb_prev_q <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            deb_prev_q <= deb;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port     = out_q;
    assign oe_port      = dir_q;
    assign irq          = irq_q;
    assign avs_readdata = readdata_q;
endmodule

// File: doc/gpio_pio_v2.md
GPIO_PIO_V2 -- requirements
Module: gpio_pio_v2

Interface
REQ-001 Parameter: WIDTH, 4, number of I/O bits (1..32).
REQ-002 Parameter: DEBOUNCE_CYCLES, 16, input stable-cycles required before acceptance; 0 bypasses the debouncer.
REQ-003 Parameter: OUT_RESET, 0, reset value of the output data register (WIDTH bits).
REQ-004 Clock and reset: one clock, clk_clk; reset is asynchronous and active-low, reset_reset_n.
REQ-005 clk_clk  input  1  system clock.
REQ-006 reset_reset_n  input  1  asynchronous active-low reset.
REQ-007 avs_address  input  3  Avalon-MM word address.
REQ-008 avs_read  input  1  read strobe.
REQ-009 avs_write  input  1  write strobe.
REQ-010 avs_writedata  input  32  write data.
REQ-011 avs_readdata  output  32  read data, valid one cycle after avs_read.
REQ-012 in_port  input  WIDTH  asynchronous external inputs (buttons, dip switches, pad readback).
REQ-013 out_port  output  WIDTH  output data register.
REQ-014 oe_port  output  WIDTH  per-bit output enable (1 = drive).
REQ-015 irq  output  1  level interrupt, active high.

Function
REQ-016 Register map (word address): 0 DATA (R: debounced input, W: out register); 1 DIR; 2 IRQ_MASK; 3 EDGE_CAP (R, write-1-to-clear); 4 OUT_SET (W1S to out); 5 OUT_CLR (W1C to out); 6 RISE_EN; 7 FALL_EN.
REQ-017 Read latency is exactly 1 cycle; avs_readdata holds its value until the next read; write-only addresses 4/5 read 0.
REQ-018 Bits [31:WIDTH] read 0; writes to them are ignored.
REQ-019 in_port passes through a 2-flop synchroniser per bit before any other logic.
REQ-020 Debounce per bit: counter increments while synchronised value differs from debounced value, clears when equal; debounced value takes synchronised value when counter reaches DEBOUNCE_CYCLES-1, counter clears.
REQ-021 With DEBOUNCE_CYCLES = 0 the debounced value equals the synchronised value (no counter logic).
REQ-022 Edge capture bit i sets on a debounced 0->1 transition when RISE_EN[i], on 1->0 when FALL_EN[i]; both enabled = any edge.
REQ-023 Capture set and a W1C on the same bit in the same cycle: set wins.
REQ-024 irq registered: irq = |(EDGE_CAP & IRQ_MASK), one cycle after the contributing register changes.
REQ-025 out_port = out register; oe_port = DIR; both are registers, no combinational path from avs inputs.
REQ-026 Simultaneous avs_read and avs_write: write commits, read returns pre-write value.
REQ-027 Debounce counter width is $clog2(DEBOUNCE_CYCLES+1); counter must not wrap.

Reset
REQ-028 On reset_reset_n low, immediately: out register = OUT_RESET, DIR = 0, IRQ_MASK = 0, EDGE_CAP = 0, RISE_EN = 0, FALL_EN = 0, irq = 0, avs_readdata = 0.
REQ-029 Synchroniser flops, debounced values and counters reset to 0; no edge is captured on the first post-reset cycle even if inputs are 1 (RISE_EN is 0).
REQ-030 Reset asserted mid-debounce discards the partial count.

Structure
REQ-031 Package gpio_pio_v2_pkg holds register address constants (ADDR_DATA .. ADDR_FALL_EN) and the data-word width constant (32).
REQ-032 One sub-module, gpio_pio_debounce (single-bit synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), instantiated WIDTH times in a generate loop.

Verification
REQ-033 Reset then read all 8 addresses -> DATA reflects in_port after settle, others 0; out_port = OUT_RESET, oe_port = 0, irq = 0.
REQ-034 DEBOUNCE_CYCLES=16: in_port[0] 0->1 with 5-cycle glitch -> no DATA change; held 1 -> DATA[0] = 1 exactly 2+16 cycles after edge.
REQ-035 RISE_EN=1, IRQ_MASK=1, debounced rise on bit 0 -> EDGE_CAP = 0x1 next cycle, irq = 1 one cycle later; write 0x1 to addr 3 -> irq = 0 two cycles later.
REQ-036 Write 0x5 to addr 0, 0x2 to addr 4, 0x1 to addr 5 -> out_port = 0x5, 0x7, 0x6 respectively one cycle after each write.
REQ-037 W1C to EDGE_CAP bit 0 in same cycle as new falling capture (FALL_EN=1) -> EDGE_CAP[0] remains 1.
REQ-038 WIDTH=32, DEBOUNCE_CYCLES=0 rebuild: in_port = 0xA5A5A5A5 -> DATA reads 0xA5A5A5A5 three cycles after applied; reset asserted mid-run clears all registers asynchronously.
